// File: rtl/counter_ext.sv
// counter_ext: up/down counter with load, enable, terminal value TOP, wrap/saturate mode.
// Optional compare-match output built when COUNTER_EXT_CMP_EN is defined.
`default_nettype none

module counter_ext #(
  parameter int            BW  = 8,
  parameter logic [BW-1:0] TOP = {BW{1'b1}},
  parameter bit            SAT = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          dir_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  input  logic [BW-1:0] cmp_val_i,
  output logic [BW-1:0] counter_val_o,
  output logic          tc_o,
  output logic          cmp_match_o
);

  logic [BW-1:0] count_q;
  logic [BW-1:0] count_next;
  logic          tc_q;
  logic          tc_next;

  always_comb begin
    count_next = count_q;
    tc_next    = 1'b0;
    if (load_i) begin
      count_next = (load_val_i > TOP) ? TOP : load_val_i;
    end else if (en_i) begin
      if (dir_i) begin
        if (count_q < TOP) begin
          count_next = count_q + 1'b1;
        end else begin
          count_next = SAT ? TOP : '0;
          tc_next    = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_next = count_q - 1'b1;
        end else begin
          count_next = SAT ? '0 : TOP;
          tc_next    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_next;
      tc_q    <= tc_next;
    end
  end

  assign counter_val_o = count_q;
  assign tc_o          = tc_q;

`ifdef COUNTER_EXT_CMP_EN
  logic cmp_q;

  // Compared against the next count so the flag lines up with counter_val_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_q <= 1'b0;
    end else begin
      cmp_q <= (count_next == cmp_val_i);
    end
  end

  assign cmp_match_o = cmp_q;
`else
  logic unused_cmp_val;
  assign unused_cmp_val = ^cmp_val_i;
  assign cmp_match_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_ext.sv
// tb_counter_ext: wrap and saturate instances (TOP=9) checked against an integer model.
`default_nettype none

module tb_counter_ext;

  localparam int BW    = 8;
  localparam int TOP_I = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          dir = 1'b1;
  logic          load = 1'b0;
  logic [BW-1:0] load_val = '0;
  logic [BW-1:0] cmp_val = '0;

  logic [BW-1:0] val0, val1;
  logic          tc0, tc1, cm0, cm1;

  int n_cmp = 0;
  int n_bad = 0;

  int m_val0 = 0, m_val1 = 0;
  bit m_tc0 = 0, m_tc1 = 0, m_cm0 = 0, m_cm1 = 0;

  always #5 clk = ~clk;

  counter_ext #(.BW(BW), .TOP(8'd9), .SAT(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
    .load_val_i(load_val), .cmp_val_i(cmp_val),
    .counter_val_o(val0), .tc_o(tc0), .cmp_match_o(cm0)
  );

  counter_ext #(.BW(BW), .TOP(8'd9), .SAT(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
    .load_val_i(load_val), .cmp_val_i(cmp_val),
    .counter_val_o(val1), .tc_o(tc1), .cmp_match_o(cm1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Wrap uses modular arithmetic on the range 0..TOP; saturate clamps.
  function automatic void model_step(input int cur, input bit sat, input bit ld,
                                     input bit e, input bit d, input int lv,
                                     output int nxt, output bit tc);
    nxt = cur;
    tc  = 1'b0;
    if (ld) begin
      nxt = (lv > TOP_I) ? TOP_I : lv;
    end else if (e) begin
      if (d) begin
        tc  = (cur == TOP_I);
        nxt = sat ? ((cur + 1 > TOP_I) ? TOP_I : cur + 1) : (cur + 1) % (TOP_I + 1);
      end else begin
        tc  = (cur == 0);
        nxt = sat ? ((cur - 1 < 0) ? 0 : cur - 1) : (cur + TOP_I) % (TOP_I + 1);
      end
    end
  endfunction

  function automatic bit model_cmp(input int nxt, input int cv);
`ifdef COUNTER_EXT_CMP_EN
    return nxt == cv;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    int n0, n1;
    bit t0, t1;
    if (rst) begin
      m_val0 <= 0; m_val1 <= 0;
      m_tc0  <= 0; m_tc1  <= 0;
      m_cm0  <= 0; m_cm1  <= 0;
    end else begin
      model_step(m_val0, 1'b0, load, en, dir, int'(load_val), n0, t0);
      model_step(m_val1, 1'b1, load, en, dir, int'(load_val), n1, t1);
      m_val0 <= n0; m_tc0 <= t0; m_cm0 <= model_cmp(n0, int'(cmp_val));
      m_val1 <= n1; m_tc1 <= t1; m_cm1 <= model_cmp(n1, int'(cmp_val));
    end
  end

  always @(negedge clk) begin
    chk("model_val_wrap", int'(val0), m_val0);
    chk("model_tc_wrap",  int'(tc0),  int'(m_tc0));
    chk("model_cmp_wrap", int'(cm0),  int'(m_cm0));
    chk("model_val_sat",  int'(val1), m_val1);
    chk("model_tc_sat",   int'(tc1),  int'(m_tc1));
    chk("model_cmp_sat",  int'(cm1),  int'(m_cm1));
  end

  initial begin
    int exp_v;
    bit use_cmp;
`ifdef COUNTER_EXT_CMP_EN
    use_cmp = 1'b1;
`else
    use_cmp = 1'b0;
`endif

    @(negedge clk);
    chk("reset_val", int'(val0), 0);
    chk("reset_tc", int'(tc0), 0);
    chk("reset_cmp", int'(cm0), 0);

    // Count up through the wrap.
    rst = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_v = (i <= 9) ? i : i - 10;
      chk("up_val", int'(val0), exp_v);
      chk("up_tc", int'(tc0), (i == 10) ? 1 : 0);
    end

    // Down wrap from 0.
    en = 1'b0; load = 1'b1; load_val = 8'd0;
    @(negedge clk);
    chk("load0_val", int'(val0), 0);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    @(negedge clk);
    chk("down_wrap_val", int'(val0), 9);
    chk("down_wrap_tc", int'(tc0), 1);
    @(negedge clk);
    chk("down_next_val", int'(val0), 8);
    chk("down_next_tc", int'(tc0), 0);

    // Saturate at TOP.
    en = 1'b0; load = 1'b1; load_val = 8'd8;
    @(negedge clk);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sat_val", int'(val1), 9);
      chk("sat_tc", int'(tc1), (i == 0) ? 0 : 1);
    end

    // Load beats enable and clamps to TOP.
    load = 1'b1; en = 1'b1; load_val = 8'd200;
    @(negedge clk);
    chk("clamp_val", int'(val0), 9);
    chk("clamp_tc", int'(tc0), 0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_val", int'(val0), 9);
      chk("hold_tc", int'(tc0), 0);
    end

    // Asynchronous reset between edges while the count is 5.
    load = 1'b1; load_val = 8'd5;
    @(negedge clk);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    chk("pre_reset_val", int'(val0), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_val", int'(val0), 0);
    chk("async_tc", int'(tc0), 0);
    chk("async_cmp", int'(cm0), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("held_reset_val", int'(val0), 0);
    end

    // Compare match while counting up from 0.
    cmp_val = 8'd4;
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("cmp_count_val", int'(val0), i);
      chk("cmp_flag", int'(cm0), (use_cmp && i == 4) ? 1 : 0);
    end

    // Randomized traffic, including occasional mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      dir      = ($urandom_range(0, 2) != 0);
      load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      cmp_val  = 8'($urandom_range(0, 10));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
